everloop_rx: RTL and testbench

EVERLOOP_RX -- requirements
Module: everloop_rx

---
 rtl/everloop_rx.sv | 178 +++++++++++++++++
 tb/tb_everloop_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/everloop_rx.sv
// everloop_rx: one-wire LED frame receiver.
// Decodes the pulse-width-encoded LED data line into bytes and emits a write per byte.
//   clk        : single clock, rising edge
//   rst        : asynchronous active-low reset
//   everloop_d : asynchronous one-wire data line (idle low)
//   address    : write address of the decoded byte (0..n_bytes)
//   data_RGB   : decoded byte, MSB received first
//   we         : one-cycle write strobe qualifying address/data_RGB
//   frame_done : one-cycle pulse at a valid end of frame
//   err        : sticky error flag, cleared on the first rising edge of the next frame
module everloop_rx #(
    parameter int unsigned input_clk_MHz = 5,
    parameter int unsigned n_bytes       = 141
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       everloop_d,
    output logic [7:0] address,
    output logic [7:0] data_RGB,
    output logic       we,
    output logic       frame_done,
    output logic       err
);

    localparam int unsigned MinHi = input_clk_MHz;
    localparam int unsigned Split = input_clk_MHz * 9 / 2;
    localparam int unsigned MaxHi = input_clk_MHz * 8;
    localparam int unsigned Gap   = input_clk_MHz * 100;
    localparam int unsigned CntW  = $clog2(Gap) + 1;

    localparam logic [CntW-1:0] MinHiC  = CntW'(MinHi);
    localparam logic [CntW-1:0] SplitC  = CntW'(Split);
    localparam logic [CntW-1:0] MaxHiC  = CntW'(MaxHi);
    localparam logic [CntW-1:0] GapC    = CntW'(Gap);
    localparam logic [7:0]      NBytesA = 8'(n_bytes);

    typedef enum logic [1:0] {StSync, StArmed, StHigh, StLow} state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync2_q, prev_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              we_q, we_d;
    logic              fd_q, fd_d;
    logic              err_q, err_d;
    logic              rise, fall;
    logic              bit_v;

    // Edges are seen on the synchronized line, two cycles after the pin.
    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    // One counter measures the current level's duration; saturates at the gap length.
    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall) begin
            cnt_d = '0;
        end else if (cnt_q != GapC) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        fd_d     = 1'b0;
        err_d    = err_q;
        bit_v    = 1'b0;

        // Address advances the cycle after the write strobe.
        if (we_q) begin
            addr_d = addr_q + 8'd1;
        end

        unique case (state_q)
            StSync: begin
                bitcnt_d = '0;
                shift_d  = '0;
                if (!sync2_q && cnt_q == GapC) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                addr_d   = '0;
                bitcnt_d = '0;
                shift_d  = '0;
                if (rise) begin
                    state_d = StHigh;
                    err_d   = 1'b0;
                end
            end
            StHigh: begin
                if (fall) begin
                    state_d = StLow;
                    if (cnt_q < MinHiC) begin
                        err_d = 1'b1;  // glitch: bit dropped, byte continues
                    end else begin
                        bit_v    = (cnt_q >= SplitC);
                        shift_d  = {shift_q[6:0], bit_v};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (addr_q == NBytesA) begin
                                err_d = 1'b1;  // frame overrun: byte discarded
                            end else begin
                                data_d = {shift_q[6:0], bit_v};
                                we_d   = 1'b1;
                            end
                        end
                    end
                end else if (cnt_q >= MaxHiC) begin
                    err_d    = 1'b1;
                    bitcnt_d = '0;
                    shift_d  = '0;
                    state_d  = StSync;
                end
            end
            StLow: begin
                if (rise) begin
                    state_d = StHigh;
                end else if (cnt_q == GapC) begin
                    state_d = StArmed;
                    if (bitcnt_q != 3'd0) begin
                        err_d    = 1'b1;
                        bitcnt_d = '0;
                        shift_d  = '0;
                    end else if (addr_q != 8'd0) begin
                        fd_d = 1'b1;
                    end
                end
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StSync;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= everloop_d;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            fd_q     <= fd_d;
            err_q    <= err_d;
        end
    end

    assign address    = addr_q;
    assign data_RGB   = data_q;
    assign we         = we_q;
    assign frame_done = fd_q;
    assign err        = err_q;

endmodule

// File: tb/tb_everloop_rx.sv
// tb_everloop_rx: directed/randomized bench for everloop_rx with a byte-level reference model.
module tb_everloop_rx;

    localparam int unsigned ClkMhz = 5;
    localparam int unsigned NBytes = 141;
    localparam int unsigned MinHi  = ClkMhz * 1;
    localparam int unsigned Split  = ClkMhz * 9 / 2;
    localparam int unsigned Gap    = ClkMhz * 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       everloop_d = 1'b0;
    logic [7:0] address;
    logic [7:0] data_RGB;
    logic       we;
    logic       frame_done;
    logic       err;

    everloop_rx #(
        .input_clk_MHz(ClkMhz),
        .n_bytes      (NBytes)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .everloop_d(everloop_d),
        .address   (address),
        .data_RGB  (data_RGB),
        .we        (we),
        .frame_done(frame_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Monitor: cumulative record of writes and frame_done pulses.
    logic [15:0] got_q[$];
    int          fd_cnt   = 0;
    int          both_cnt = 0;
    logic [7:0]  fd_addr  = 8'd0;

    always @(negedge clk) begin
        if (we) got_q.push_back({address, data_RGB});
        if (frame_done) begin
            fd_cnt  = fd_cnt + 1;
            fd_addr = address;
        end
        if (we && frame_done) both_cnt = both_cnt + 1;
    end

    // Reference model state: a frame is a list of pulses, bits group into bytes.
    logic [15:0] exp_q[$];
    bit          m_synced;
    bit          m_armed;
    int          m_bits;
    logic [7:0]  m_shift;
    int          m_nbytes;
    logic        exp_err;
    int          exp_fd;
    logic [7:0]  exp_fd_addr;

    int checks = 0;
    int errors = 0;
    int chk_idx = 0;
    int fd_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_synced = 1'b0;
        m_armed  = 1'b0;
        m_bits   = 0;
        m_shift  = 8'd0;
        m_nbytes = 0;
        exp_err  = 1'b0;
    endtask

    task automatic model_pulse(input int h);
        logic b;
        if (!m_synced) return;
        if (m_armed) begin
            exp_err = 1'b0;
            m_armed = 1'b0;
        end
        if (h < int'(MinHi)) begin
            exp_err = 1'b1;
            return;
        end
        b       = (h >= int'(Split));
        m_shift = {m_shift[6:0], b};
        m_bits++;
        if (m_bits == 8) begin
            m_bits = 0;
            if (m_nbytes < int'(NBytes)) exp_q.push_back({8'(m_nbytes), m_shift});
            else exp_err = 1'b1;
            m_nbytes++;
        end
    endtask

    task automatic model_gap(input int n);
        if (n < int'(Gap)) return;
        if (!m_synced) begin
            m_synced = 1'b1;
            m_armed  = 1'b1;
            m_bits   = 0;
            return;
        end
        if (m_bits != 0) begin
            exp_err = 1'b1;
            m_bits  = 0;
        end else if (m_nbytes > 0) begin
            exp_fd++;
            exp_fd_addr = (m_nbytes < int'(NBytes)) ? 8'(m_nbytes) : 8'(NBytes);
        end
        m_nbytes = 0;
        m_armed  = 1'b1;
    endtask

    task automatic seg(input logic lvl, input int n);
        everloop_d = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int h, input int l);
        model_pulse(h);
        seg(1'b1, h);
        seg(1'b0, l);
    endtask

    task automatic send_bit(input logic b, input bit fixed);
        if (fixed) begin
            if (b) pulse(30, 30);
            else pulse(15, 45);
        end else begin
            if (b) pulse(int'($urandom_range(27, 24)), int'($urandom_range(6, 3)));
            else pulse(int'($urandom_range(10, 7)), int'($urandom_range(6, 3)));
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit fixed);
        for (int i = 7; i >= 0; i--) send_bit(d[i], fixed);
    endtask

    task automatic low_gap(input int n);
        model_gap(n);
        seg(1'b0, n);
    endtask

    task automatic finish_scn(input string tag);
        check({tag, "_we_count"}, got_q.size(), exp_q.size());
        for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_write"}, got_q[i], exp_q[i]);
        end
        chk_idx = exp_q.size();
        check({tag, "_fd_count"}, fd_cnt, exp_fd);
        if (exp_fd != fd_seen) check({tag, "_fd_addr"}, fd_addr, exp_fd_addr);
        fd_seen = exp_fd;
        check({tag, "_err"}, err, exp_err);
        check({tag, "_we_fd_overlap"}, both_cnt, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] base;
        exp_fd      = 0;
        exp_fd_addr = 8'd0;
        model_reset();

        repeat (5) @(negedge clk);
        check("reset_outputs", {address, data_RGB, we, frame_done, err}, 32'd0);
        rst = 1'b1;

        // Single byte 0xA5 with nominal pulse widths.
        low_gap(510);
        send_byte(8'hA5, 1'b1);
        low_gap(510);
        finish_scn("byte_a5");

        // Full frame of incrementing data, long transmitter gap.
        base = 8'($urandom_range(255, 0));
        for (int i = 0; i < int'(NBytes); i++) send_byte(base + 8'(i), 1'b0);
        low_gap(4075);
        finish_scn("full_frame");

        // Glitch inside a byte; byte still completes from 8 valid bits.
        d = 8'($urandom);
        for (int i = 7; i >= 4; i--) send_bit(d[i], 1'b0);
        pulse(3, 30);
        for (int i = 3; i >= 0; i--) send_bit(d[i], 1'b0);
        send_byte(8'($urandom), 1'b0);
        low_gap(510);
        finish_scn("glitch");

        // Partial byte then gap: no write, no frame_done, err set.
        d = 8'($urandom);
        for (int i = 7; i >= 4; i--) send_bit(d[i], 1'b0);
        low_gap(510);
        finish_scn("partial");
        // err clears on the next rising edge.
        model_pulse(26);
        seg(1'b1, 8);
        check("err_clear", err, exp_err);
        seg(1'b1, 18);
        seg(1'b0, 5);
        d = 8'($urandom);
        for (int i = 6; i >= 0; i--) send_bit(d[i], 1'b0);
        low_gap(510);
        finish_scn("after_partial");

        // Overrun: one byte more than the frame holds.
        for (int i = 0; i < int'(NBytes) + 1; i++) send_byte(8'($urandom), 1'b0);
        low_gap(510);
        finish_scn("overrun");

        // Reset mid-byte, then data must be ignored until a full gap.
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        seg(1'b1, 5);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset_outputs", {address, data_RGB, we, frame_done, err}, 32'd0);
        model_reset();
        everloop_d = 1'b0;
        rst = 1'b1;
        send_byte(8'($urandom), 1'b0);
        finish_scn("post_reset_ignored");
        low_gap(510);
        send_byte(8'($urandom), 1'b0);
        low_gap(510);
        finish_scn("post_reset_resume");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
